alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle flag-generating ALU: one SEG-bit slice per clock, LSB segment first,
// with a registered inter-segment carry and a stored carry flag for ADC/SBB chaining.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic             out_valid,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);

    localparam int NSEG = WIDTH / SEG;
    localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     xr;
    logic [WIDTH-1:0]     yr;
    logic [WIDTH-SEG-1:0] res;
    logic [2:0]           opr;
    logic                 c;
    logic [KW-1:0]        k;

    logic [SEG-1:0]       xs;
    logic [SEG-1:0]       ys;
    logic [SEG:0]         sum;
    logic [SEG-1:0]       seg_out;
    logic [WIDTH-1:0]     z_next;
    logic                 last;
    logic                 accept;
    logic                 arith;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // Operands shift right each segment, so the active slice always sits in the low SEG bits
    // and the partial result fills in from the top.
    always_comb begin
        accept = in_valid && in_ready;
        last   = (state == RUN) && (k == KW'(NSEG - 1));
        arith  = ~opr[2];
        xs     = xr[SEG-1:0];
        ys     = yr[SEG-1:0];
        sum    = {1'b0, xs} + {1'b0, ys} + {{SEG{1'b0}}, c};
        case (opr)
            3'b100:  seg_out = xs & ys;
            3'b101:  seg_out = xs | ys;
            3'b110:  seg_out = xs ^ ys;
            3'b111:  seg_out = xs;
            default: seg_out = sum[SEG-1:0];
        endcase
        z_next = {seg_out, res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr  <= '0;
            yr  <= '0;
            res <= '0;
            opr <= '0;
            c   <= 1'b0;
            k   <= '0;
        end else if (accept) begin
            xr  <= X;
            yr  <= (op[2:1] == 2'b01) ? ~Y : Y;
            opr <= op;
            k   <= '0;
            case (op)
                3'b001, 3'b011: c <= carry;
                3'b010:         c <= 1'b1;
                default:        c <= 1'b0;
            endcase
        end else if (state == RUN) begin
            xr  <= xr >> SEG;
            yr  <= yr >> SEG;
            res <= z_next[WIDTH-1:SEG];
            c   <= sum[SEG];
            k   <= k + 1'b1;
        end
    end

    // On the final segment xs/ys hold the operand MSB slices, giving the overflow inputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Z         <= '0;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            parity    <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            out_valid <= last;
            if (last) begin
                Z        <= z_next;
                sign     <= seg_out[SEG-1];
                zero     <= ~|z_next;
                carry    <= arith & sum[SEG];
                parity   <= ~^z_next;
                overflow <= arith & (xs[SEG-1] == ys[SEG-1]) & (seg_out[SEG-1] != xs[SEG-1]);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; flags are compared as {sign,zero,carry,parity,overflow}.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] Z;
    logic        out_valid;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(16), .SEG(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .X        (X),
        .Y        (Y),
        .Z        (Z),
        .out_valid(out_valid),
        .sign     (sign),
        .zero     (zero),
        .carry    (carry),
        .parity   (parity),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op, scrambles the inputs after accept, and waits (bounded) for out_valid.
    task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int cyc, output int busy);
        @(negedge clk);
        op = o; X = a; Y = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 3'b000; X = 16'hDEAD; Y = 16'hBEEF;
        cyc = 0;
        busy = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!in_ready) busy++;
            if (out_valid) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; X = '0; Y = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, Z} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_state: got rdy=%b ov=%b Z=%h expected rdy=1 ov=0 Z=0000", in_ready, out_valid, Z);
        end
        checks++;
        if ({sign, zero, carry, parity, overflow} !== 5'b01010) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 01010", {sign, zero, carry, parity, overflow});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow;
        int cyc, busy;
        do_op(3'b000, 16'h7FFF, 16'h0001, cyc, busy);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("[TB] FAIL add_latency: got %0d expected 5", cyc);
        end
        checks++;
        if (Z !== 16'h8000) begin
            errors++;
            $display("[TB] FAIL add_z: got %h expected 8000", Z);
        end
        checks++;
        if ({sign, zero, carry, parity, overflow} !== 5'b10001) begin
            errors++;
            $display("[TB] FAIL add_flags: got %b expected 10001", {sign, zero, carry, parity, overflow});
        end
    endtask

    task automatic test_add_carry_adc;
        int cyc, busy;
        do_op(3'b000, 16'hFFFF, 16'h0001, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'h0000, 5'b01110}) begin
            errors++;
            $display("[TB] FAIL add_carry: got Z=%h flags=%b expected Z=0000 flags=01110",
                     Z, {sign, zero, carry, parity, overflow});
        end
        do_op(3'b001, 16'h0000, 16'h0000, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'h0001, 5'b00000}) begin
            errors++;
            $display("[TB] FAIL adc: got Z=%h flags=%b expected Z=0001 flags=00000",
                     Z, {sign, zero, carry, parity, overflow});
        end
    endtask

    task automatic test_sub_sbb;
        int cyc, busy;
        do_op(3'b010, 16'h0003, 16'h0005, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'hFFFE, 5'b10000}) begin
            errors++;
            $display("[TB] FAIL sub: got Z=%h flags=%b expected Z=fffe flags=10000",
                     Z, {sign, zero, carry, parity, overflow});
        end
        do_op(3'b011, 16'h0010, 16'h0000, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'h000F, 5'b00110}) begin
            errors++;
            $display("[TB] FAIL sbb: got Z=%h flags=%b expected Z=000f flags=00110",
                     Z, {sign, zero, carry, parity, overflow});
        end
    endtask

    task automatic test_logic;
        int cyc, busy;
        do_op(3'b110, 16'hA5A5, 16'hFFFF, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'h5A5A, 5'b00010}) begin
            errors++;
            $display("[TB] FAIL xor: got Z=%h flags=%b expected Z=5a5a flags=00010",
                     Z, {sign, zero, carry, parity, overflow});
        end
        checks++;
        if (busy !== 4) begin
            errors++;
            $display("[TB] FAIL xor_busy: got %0d expected 4", busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pulse_width: got out_valid=%b expected 0", out_valid);
        end
        do_op(3'b100, 16'hF0F0, 16'h3C3C, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'h3030, 5'b00010}) begin
            errors++;
            $display("[TB] FAIL and: got Z=%h flags=%b expected Z=3030 flags=00010",
                     Z, {sign, zero, carry, parity, overflow});
        end
        do_op(3'b111, 16'h1234, 16'hFFFF, cyc, busy);
        checks++;
        if ({Z, sign, zero, carry, parity, overflow} !== {16'h1234, 5'b00000}) begin
            errors++;
            $display("[TB] FAIL pass: got Z=%h flags=%b expected Z=1234 flags=00000",
                     Z, {sign, zero, carry, parity, overflow});
        end
        checks++;
        if (busy !== 4) begin
            errors++;
            $display("[TB] FAIL pass_busy: got %0d expected 4", busy);
        end
    endtask

    // in_valid held high throughout; only the operands present at edges 0 and 5 may be taken.
    task automatic test_back_to_back;
        int pulses;
        logic stable;
        pulses = 0;
        stable = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; X = 16'h1111; Y = 16'h2222;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
            if (i == 5) begin
                checks++;
                if ({out_valid, in_ready, Z, sign, zero, carry, parity, overflow} !== {2'b11, 16'h3333, 5'b00010}) begin
                    errors++;
                    $display("[TB] FAIL b2b_first: got ov=%b rdy=%b Z=%h flags=%b expected ov=1 rdy=1 Z=3333 flags=00010",
                             out_valid, in_ready, Z, {sign, zero, carry, parity, overflow});
                end
            end
            if (i >= 6 && i <= 9 && (Z !== 16'h3333 || in_ready !== 1'b0)) stable = 1'b0;
            if (i == 10) begin
                checks++;
                if ({out_valid, in_ready, Z, sign, zero, carry, parity, overflow} !== {2'b11, 16'h0FF0, 5'b00010}) begin
                    errors++;
                    $display("[TB] FAIL b2b_second: got ov=%b rdy=%b Z=%h flags=%b expected ov=1 rdy=1 Z=0ff0 flags=00010",
                             out_valid, in_ready, Z, {sign, zero, carry, parity, overflow});
                end
            end
            if (i == 5) begin
                op = 3'b101; X = 16'h00F0; Y = 16'h0F00;
            end else if (i >= 10) begin
                in_valid = 1'b0;
            end else begin
                op = 3'b110; X = 16'hFFFF; Y = 16'(i);
            end
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got stable=%b expected 1", stable);
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_reset_abort;
        int cyc, busy, pulses;
        pulses = 0;
        @(negedge clk);
        op = 3'b000; X = 16'h00FF; Y = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, Z, sign, zero, carry, parity, overflow} !== {2'b10, 16'h0000, 5'b01010}) begin
            errors++;
            $display("[TB] FAIL abort_state: got rdy=%b ov=%b Z=%h flags=%b expected rdy=1 ov=0 Z=0000 flags=01010",
                     in_ready, out_valid, Z, {sign, zero, carry, parity, overflow});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_pulse: got %0d expected 0", pulses);
        end
        do_op(3'b000, 16'h00FF, 16'h0001, cyc, busy);
        checks++;
        if ({cyc, Z, sign, zero, carry, parity, overflow} !== {32'd5, 16'h0100, 5'b00000}) begin
            errors++;
            $display("[TB] FAIL abort_recover: got cyc=%0d Z=%h flags=%b expected cyc=5 Z=0100 flags=00000",
                     cyc, Z, {sign, zero, carry, parity, overflow});
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_add_carry_adc();
        test_sub_sbb();
        test_logic();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
